// File: rtl/uart8_echo_responder.sv
// uart8_echo_responder
//   Far-end echo responder for a Uart8 link. Every byte completed by the local
//   receiver is queued in a small FIFO. The queued bytes are then sent back, in
//   order, through the local transmitter using the txStart/txBusy/txDone
//   handshake. Framing errors and FIFO overflows are counted so that a loopback
//   link test can check itself.
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-high reset
//   en                responder enable, forwarded to rxEn/txEn
//   clrStatus         sync pulse: clears overflow, timeout, errCount, dropCount
//   rxDone/rxErr/rxOut  receiver side: byte complete, frame error, data
//   rxEn/txEn         enables for the attached Uart8
//   txStart/txIn      transmit request and byte (txIn stable while txStart=1)
//   txBusy/txDone     transmitter status
//   fifoCount         bytes queued, not counting the byte in flight
//   overflow/timeout  sticky status flags
//   errCount/dropCount  saturating counters of bad frames / dropped bytes
module uart8_echo_responder #(
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_WIDTH     = 8,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clrStatus,
    input  logic                          rxDone,
    input  logic                          rxErr,
    input  logic [7:0]                    rxOut,
    output logic                          rxEn,
    output logic                          txEn,
    output logic                          txStart,
    output logic [7:0]                    txIn,
    input  logic                          txBusy,
    input  logic                          txDone,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          overflow,
    output logic                          timeout,
    output logic [CNT_WIDTH-1:0]          errCount,
    output logic [CNT_WIDTH-1:0]          dropCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, SEND} state_t;

    state_t          state, state_nx;
    logic            rx_done_q, tx_done_q, tx_busy_q;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [TW-1:0]   tmo_cnt;
    logic            capture, good, full, push, pop, drop, tmo_hit;

    assign rxEn = en;
    assign txEn = en;

    // A held rxDone level produces a single capture because only the rising
    // edge counts; the edge register tracks rxDone even while disabled.
    assign capture = en && rxDone && !rx_done_q;
    assign good    = capture && !rxErr;
    assign full    = (fifoCount == CW'(FIFO_DEPTH));
    // LOAD is only entered with a non-empty FIFO, so no empty check is needed.
    assign pop     = (state == LOAD) && en;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push    = good && (!full || pop);
    assign drop    = good && full && !pop;

    // ---------------- edge detect ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_busy_q <= 1'b0;
        end else begin
            rx_done_q <= rxDone;
            tx_done_q <= txDone;
            tx_busy_q <= txBusy;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rxOut;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
            txIn      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                txIn   <= mem[rd_ptr];
            end
            if (push && !pop)      fifoCount <= fifoCount + CW'(1);
            else if (pop && !push) fifoCount <= fifoCount - CW'(1);
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCount  <= '0;
            dropCount <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else if (clrStatus) begin
            errCount  <= '0;
            dropCount <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (capture && rxErr && (errCount != '1)) errCount <= errCount + CNT_WIDTH'(1);
            if (drop && (dropCount != '1))            dropCount <= dropCount + CNT_WIDTH'(1);
            if (drop)                                 overflow <= 1'b1;
            if (tmo_hit)                              timeout  <= 1'b1;
        end
    end

    // ---------------- tx FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Cycles spent in START; zero on the first START cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               tmo_cnt <= '0;
        else if (state != START) tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + TW'(1);
    end

    always_comb begin
        state_nx = state;
        txStart  = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            IDLE:  if (en && (fifoCount != '0)) state_nx = LOAD;
            LOAD:  state_nx = en ? START : IDLE;
            START: begin
                txStart = 1'b1;
                if (txBusy) begin
                    state_nx = SEND;
                end else if (tmo_cnt == TW'(START_TIMEOUT - 1)) begin
                    state_nx = IDLE;
                    tmo_hit  = 1'b1;
                end
            end
            SEND:  if ((txDone && !tx_done_q) || (!txBusy && tx_busy_q)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart8_echo_responder.sv
// Self-checking bench for uart8_echo_responder. A small behavioural transmitter
// agent answers txStart and records every byte offered for transmission; the
// reference model is a queue of bytes expected back plus saturating counters.
module tb_uart8_echo_responder;

    localparam int DEPTH  = 4;
    localparam int CW     = 3;
    localparam int TMO    = 16;
    localparam int SATMAX = (1 << CW) - 1;

    logic        clk, reset, en, clrStatus, rxDone, rxErr;
    logic [7:0]  rxOut;
    logic        rxEn, txEn, txStart, txBusy, txDone;
    logic [7:0]  txIn;
    logic [2:0]  fifoCount;
    logic        overflow, timeout;
    logic [CW-1:0] errCount, dropCount;

    uart8_echo_responder #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .en(en), .clrStatus(clrStatus),
        .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
        .rxEn(rxEn), .txEn(txEn), .txStart(txStart), .txIn(txIn),
        .txBusy(txBusy), .txDone(txDone), .fifoCount(fifoCount),
        .overflow(overflow), .timeout(timeout),
        .errCount(errCount), .dropCount(dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // tx agent: mode 0 = normal frame of tx_len cycles, 1 = busy stuck high,
    // 2 = dead (never busy)
    int tx_mode = 0;
    int tx_len  = 2;
    logic [7:0] echo_q[$];
    logic [7:0] exp_q[$];

    initial begin
        int tx_cnt;
        tx_cnt = 0;
        txBusy = 1'b0;
        txDone = 1'b0;
        forever begin
            @(negedge clk);
            txDone = 1'b0;
            if (tx_mode == 0) begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin txBusy = 1'b0; txDone = 1'b1; end
                end else begin
                    txBusy = 1'b0;
                    if (txStart === 1'b1) begin
                        echo_q.push_back(txIn);
                        txBusy = 1'b1;
                        tx_cnt = tx_len;
                    end
                end
            end else if (tx_mode == 1) begin
                txBusy = 1'b1;
                if (txStart === 1'b1) echo_q.push_back(txIn);
            end else begin
                txBusy = 1'b0;
                tx_cnt = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic err, input int gap);
        @(negedge clk);
        rxOut = b; rxErr = err; rxDone = 1'b1;
        @(negedge clk);
        rxDone = 1'b0; rxErr = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_echo(input int n);
        int k;
        k = 0;
        while (echo_q.size() < n && k < 600) begin @(negedge clk); k++; end
        repeat (30) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); clrStatus = 1'b1;
        @(negedge clk); clrStatus = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; clrStatus = 1'b0;
        rxDone = 1'b0; rxErr = 1'b0; rxOut = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (txStart !== 1'b0)   begin bad++; $display("FAIL reset_txStart got=%b want=0", txStart); end
        total++; if (txIn !== 8'h00)     begin bad++; $display("FAIL reset_txIn got=%h want=00", txIn); end
        total++; if (fifoCount !== 3'd0) begin bad++; $display("FAIL reset_fifoCount got=%0d want=0", fifoCount); end
        total++; if (overflow !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", overflow, timeout); end
        total++; if (errCount !== '0 || dropCount !== '0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", errCount, dropCount); end
        total++; if (rxEn !== 1'b0 || txEn !== 1'b0) begin bad++; $display("FAIL reset_enables got=%b%b want=00", rxEn, txEn); end
        reset = 1'b0;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        total++; if (rxEn !== 1'b1 || txEn !== 1'b1) begin bad++; $display("FAIL enables_follow_en got=%b%b want=11", rxEn, txEn); end
    endtask

    task automatic test_single_echo(input logic [7:0] b);
        echo_q = {}; exp_q = {b};
        @(negedge clk);
        rxOut = b; rxErr = 1'b0; rxDone = 1'b1;
        @(posedge clk); #1;
        total++; if (fifoCount !== 3'd1) begin bad++; $display("FAIL single_queued got=%0d want=1", fifoCount); end
        @(negedge clk); rxDone = 1'b0;
        @(posedge clk); #1;
        total++; if (txStart !== 1'b0) begin bad++; $display("FAIL single_early_start got=%b want=0", txStart); end
        @(posedge clk); #1;
        total++; if (txStart !== 1'b1 || txIn !== b) begin bad++; $display("FAIL single_latency got=%b/%h want=1/%h", txStart, txIn, b); end
        wait_echo(1);
        total++; if (echo_q.size() != 1 || echo_q[0] !== b) begin bad++; $display("FAIL single_echo got_n=%0d want=%h", echo_q.size(), b); end
        total++; if (errCount !== '0 || fifoCount !== 3'd0) begin bad++; $display("FAIL single_status got=%0d/%0d want=0/0", errCount, fifoCount); end
    endtask

    task automatic test_burst();
        int peak;
        peak = 0;
        echo_q = {}; exp_q = {};
        tx_len = 5;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b0, 1);
            exp_q.push_back(8'(i));
            if (int'(fifoCount) > peak) peak = int'(fifoCount);
        end
        wait_echo(5);
        total++; if (echo_q.size() != 5) begin bad++; $display("FAIL burst_count got=%0d want=5", echo_q.size()); end
        for (int i = 0; i < 5 && i < echo_q.size(); i++) begin
            total++; if (echo_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_order[%0d] got=%h want=%h", i, echo_q[i], exp_q[i]); end
        end
        total++; if (peak < 1 || fifoCount !== 3'd0 || overflow !== 1'b0) begin bad++; $display("FAIL burst_fifo peak=%0d end=%0d ovf=%b want >=1/0/0", peak, fifoCount, overflow); end
        tx_len = 2;
    endtask

    task automatic test_random();
        int m_err;
        logic [7:0] b;
        logic e;
        pulse_clr();
        m_err = 0;
        echo_q = {}; exp_q = {};
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            e = ($urandom_range(0, 7) == 0);
            send_byte(b, e, $urandom_range(6, 14));
            if (e) m_err = (m_err >= SATMAX) ? SATMAX : m_err + 1;
            else   exp_q.push_back(b);
        end
        wait_echo(exp_q.size());
        total++; if (echo_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count got=%0d want=%0d", echo_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < echo_q.size(); i++) begin
            total++; if (echo_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_data[%0d] got=%h want=%h", i, echo_q[i], exp_q[i]); end
        end
        total++; if (errCount !== CW'(m_err)) begin bad++; $display("FAIL random_errCount got=%0d want=%0d", errCount, m_err); end
    endtask

    task automatic test_error_clear();
        pulse_clr();
        total++; if (errCount !== '0) begin bad++; $display("FAIL err_clear0 got=%0d want=0", errCount); end
        echo_q = {};
        send_byte(8'h5A, 1'b1, 4);
        repeat (20) @(negedge clk);
        total++; if (errCount !== CW'(1) || echo_q.size() != 0) begin bad++; $display("FAIL err_one got=%0d/%0d want=1/0", errCount, echo_q.size()); end
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1, 2);
        @(negedge clk);
        total++; if (errCount !== CW'(SATMAX)) begin bad++; $display("FAIL err_saturate got=%0d want=%0d", errCount, SATMAX); end
        pulse_clr();
        total++; if (errCount !== '0) begin bad++; $display("FAIL err_clear got=%0d want=0", errCount); end
        send_byte(8'h11, 1'b1, 2);
        @(negedge clk);
        rxOut = 8'h22; rxErr = 1'b1; rxDone = 1'b1; clrStatus = 1'b1;
        @(negedge clk);
        rxDone = 1'b0; rxErr = 1'b0; clrStatus = 1'b0;
        @(negedge clk);
        total++; if (errCount !== '0) begin bad++; $display("FAIL err_clear_wins got=%0d want=0", errCount); end
    endtask

    task automatic test_overflow();
        int n, acc;
        pulse_clr();
        echo_q = {}; exp_q = {};
        tx_mode = 1;
        repeat (3) @(negedge clk);
        n = 7;
        // one byte sits in the transmit register, DEPTH more fit in the FIFO
        acc = (n < DEPTH + 1) ? n : DEPTH + 1;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_byte(b, 1'b0, 6);
            if (i < acc) exp_q.push_back(b);
        end
        total++; if (fifoCount !== 3'(DEPTH)) begin bad++; $display("FAIL ovf_fifoCount got=%0d want=%0d", fifoCount, DEPTH); end
        total++; if (dropCount !== CW'(n - acc) || overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop got=%0d/%b want=%0d/1", dropCount, overflow, n - acc); end
        tx_mode = 0;
        wait_echo(acc);
        total++; if (echo_q.size() != acc) begin bad++; $display("FAIL ovf_echo_count got=%0d want=%0d", echo_q.size(), acc); end
        for (int i = 0; i < acc && i < echo_q.size(); i++) begin
            total++; if (echo_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_data[%0d] got=%h want=%h", i, echo_q[i], exp_q[i]); end
        end
        pulse_clr();
        total++; if (overflow !== 1'b0 || dropCount !== '0) begin bad++; $display("FAIL ovf_clear got=%b/%0d want=0/0", overflow, dropCount); end
    endtask

    task automatic test_enable();
        int k;
        echo_q = {};
        exp_q = {8'hA1, 8'hB2, 8'hC3};
        tx_len = 20;
        send_byte(8'hA1, 1'b0, 1);
        k = 0;
        while (txBusy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        send_byte(8'hB2, 1'b0, 1);
        send_byte(8'hC3, 1'b0, 1);
        @(negedge clk); en = 1'b0;
        #1;
        total++; if (rxEn !== 1'b0 || txEn !== 1'b0) begin bad++; $display("FAIL en_off_enables got=%b%b want=00", rxEn, txEn); end
        send_byte(8'hD4, 1'b0, 2);
        repeat (40) @(negedge clk);
        total++; if (echo_q.size() != 1 || fifoCount !== 3'd2) begin bad++; $display("FAIL en_off_hold got=%0d/%0d want=1/2", echo_q.size(), fifoCount); end
        total++; if (txStart !== 1'b0) begin bad++; $display("FAIL en_off_idle got=%b want=0", txStart); end
        en = 1'b1;
        tx_len = 2;
        wait_echo(3);
        total++; if (echo_q.size() != 3) begin bad++; $display("FAIL en_drain_count got=%0d want=3", echo_q.size()); end
        for (int i = 0; i < 3 && i < echo_q.size(); i++) begin
            total++; if (echo_q[i] !== exp_q[i]) begin bad++; $display("FAIL en_drain[%0d] got=%h want=%h", i, echo_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int k, hi;
        logic [7:0] y;
        echo_q = {};
        tx_mode = 2;
        send_byte(8'h3C, 1'b0, 1);
        k = 0;
        while (txStart !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        hi = 0;
        while (txStart === 1'b1 && hi < 40) begin hi++; @(posedge clk); #1; end
        total++; if (hi != TMO) begin bad++; $display("FAIL tmo_start_width got=%0d want=%0d", hi, TMO); end
        total++; if (timeout !== 1'b1 || echo_q.size() != 0) begin bad++; $display("FAIL tmo_flag got=%b/%0d want=1/0", timeout, echo_q.size()); end
        @(negedge clk);
        tx_mode = 0;
        y = 8'($urandom);
        send_byte(y, 1'b0, 2);
        wait_echo(1);
        total++; if (echo_q.size() != 1 || echo_q[0] !== y) begin bad++; $display("FAIL tmo_next_byte got_n=%0d want=%h", echo_q.size(), y); end
        pulse_clr();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", timeout); end
    endtask

    task automatic test_reset_mid();
        echo_q = {};
        tx_mode = 2;
        send_byte(8'h77, 1'b0, 2);
        send_byte(8'h88, 1'b0, 2);
        @(posedge clk); #1;
        total++; if (txStart !== 1'b1 || fifoCount !== 3'd1) begin bad++; $display("FAIL rst_mid_pre got=%b/%0d want=1/1", txStart, fifoCount); end
        #2 reset = 1'b1;
        #1;
        total++; if (txStart !== 1'b0 || fifoCount !== 3'd0) begin bad++; $display("FAIL rst_mid_async got=%b/%0d want=0/0", txStart, fifoCount); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tx_mode = 0;
        repeat (30) @(negedge clk);
        total++; if (echo_q.size() != 0 || timeout !== 1'b0) begin bad++; $display("FAIL rst_mid_lost got=%0d/%b want=0/0", echo_q.size(), timeout); end
    endtask

    initial begin
        test_reset();
        test_single_echo(8'b10001010);
        test_single_echo(8'($urandom));
        test_burst();
        test_random();
        test_error_clear();
        test_overflow();
        test_enable();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
